disp_arb: RTL and testbench

Display-source arbiter and scheduler for the board's 8-digit seven-segment scanner. It chooses which 32-bit word the scanner shows from NSRC CPU debug sources, such as PC, instruction, ALU result and memory data. Source selection is either auto-rotate on a dwell timer or manual via a debounced push-button. One urgent requester, such as a trap or halt reporter, can preempt the display through a req/gnt handshake. The registered `digit` output feeds the scanner's 32-bit digit input.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/disp_arb.sv | 121 ++++++++++++
 tb/tb_disp_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and default timing constants for the display arbiter
package disp_pkg;

  typedef enum logic [1:0] {
    SHOW   = 2'd0,
    PRIO   = 2'd1,
    LINGER = 2'd2
  } state_t;

  localparam int WORD_W        = 32;
  localparam int DWELL_DEF     = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;
  localparam int HOLD_DEF      = 50_000_000;

  // Counter width for a count of n cycles; never zero so tiny parameters still elaborate.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, stability filter and rising-edge step pulse
module btn_debounce
  import disp_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse
);

  localparam int CW = cnt_w(DB_CYCLES);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_diff;
  logic          w_accept;

  // The level flips only after DB_CYCLES consecutive samples disagree with it.
  assign w_diff   = (r_sync[1] != r_level);
  assign w_accept = w_diff && (r_cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_in};
      r_pulse <= w_accept & r_sync[1];
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/disp_arb.sv
// rtl/disp_arb.sv - display source arbiter with auto/manual rotation and urgent preemption
// Urgent handshake and linger FSM are present only when DISP_ARB_PRIO_EN is defined.
module disp_arb
  import disp_pkg::*;
#(
  parameter int NSRC      = 4,
  parameter int DWELL     = DWELL_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int HOLD      = HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NSRC*WORD_W-1:0]   src_data,
  input  logic                     auto_en,
  input  logic                     btn_next,
  input  logic                     pri_req,
  input  logic [WORD_W-1:0]        pri_data,
  output logic                     pri_gnt,
  output logic [WORD_W-1:0]        digit,
  output logic [$clog2(NSRC)-1:0]  sel,
  output logic                     pri_active
);

  localparam int SW = $clog2(NSRC);
  localparam int DW = cnt_w(DWELL);
  localparam int HW = cnt_w(HOLD);

  logic              w_step;
  state_t            w_state;
  logic [SW-1:0]     r_sel;
  logic [DW-1:0]     r_dwell;
  logic [WORD_W-1:0] r_digit;
  logic              w_expire;
  logic              w_advance;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_next),
    .pulse  (w_step)
  );

`ifdef DISP_ARB_PRIO_EN
  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_linger;
  logic [HW-1:0] w_linger_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= SHOW;
      r_linger <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_linger <= w_linger_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_linger_nxt = r_linger;
    case (r_state)
      SHOW: if (pri_req) w_state_nxt = PRIO;
      PRIO: begin
        if (!pri_req) begin
          w_state_nxt  = LINGER;
          w_linger_nxt = '0;
        end
      end
      LINGER: begin
        if (pri_req) begin
          w_state_nxt = PRIO;
        end else if (r_linger == HW'(HOLD - 1)) begin
          w_state_nxt = SHOW;
        end else begin
          w_linger_nxt = r_linger + HW'(1);
        end
      end
      default: w_state_nxt = SHOW;
    endcase
  end

  assign w_state = r_state;
`else
  logic w_unused;
  assign w_unused = &{1'b0, pri_req, HW'(0)};
  assign w_state  = SHOW;
`endif

  // A step and a dwell expiry on the same cycle collapse into one advance.
  assign w_expire  = auto_en && (r_dwell == DW'(DWELL - 1));
  assign w_advance = (w_state == SHOW) && (w_step || w_expire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel   <= '0;
      r_dwell <= '0;
      r_digit <= '0;
    end else begin
      if ((w_state != SHOW) || !auto_en || w_advance) begin
        r_dwell <= '0;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
      if (w_advance) begin
        r_sel <= (r_sel == SW'(NSRC - 1)) ? '0 : r_sel + SW'(1);
      end
      case (w_state)
        SHOW:    r_digit <= src_data[r_sel*WORD_W +: WORD_W];
        PRIO:    r_digit <= pri_data;
        default: r_digit <= r_digit;
      endcase
    end
  end

  assign pri_gnt    = (w_state == PRIO);
  assign pri_active = (w_state != SHOW);
  assign digit      = r_digit;
  assign sel        = r_sel;

endmodule

// File: tb/tb_disp_arb.sv
// tb/tb_disp_arb.sv - directed self-checking bench for disp_arb
module tb_disp_arb;

  localparam int NSRC = 4;
  localparam int DWELL = 8;
  localparam int DB = 4;
  localparam int HOLD = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic [NSRC*32-1:0] src_data;
  logic               auto_en;
  logic               btn_next;
  logic               pri_req;
  logic [31:0]        pri_data;
  logic               pri_gnt;
  logic [31:0]        digit;
  logic [1:0]         sel;
  logic               pri_active;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_arb #(.NSRC(NSRC), .DWELL(DWELL), .DB_CYCLES(DB), .HOLD(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_data   (src_data),
    .auto_en    (auto_en),
    .btn_next   (btn_next),
    .pri_req    (pri_req),
    .pri_data   (pri_data),
    .pri_gnt    (pri_gnt),
    .digit      (digit),
    .sel        (sel),
    .pri_active (pri_active)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; auto_en = 1'b0; btn_next = 1'b0; pri_req = 1'b0; pri_data = 32'h0;
    for (int i = 0; i < NSRC; i++) src_data[i*32 +: 32] = 32'h0000_00A0 + i;
    tick(); tick();
    n_checks++; if (digit !== 32'h0) begin n_fail++; $display("FAIL reset_digit got=%h exp=%h", digit, 32'h0); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_checks++; if (pri_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0", pri_gnt); end
    n_checks++; if (pri_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", pri_active); end
    reset = 1'b1;
    tick();
    n_checks++; if (digit !== 32'hA0) begin n_fail++; $display("FAIL post_reset_digit got=%h exp=%h", digit, 32'hA0); end
  endtask

  task automatic test_auto_rotate();
    logic [1:0]  exp_sel;
    logic [31:0] exp_dig;
    auto_en = 1'b1;
    for (int i = 1; i <= 4 * DWELL; i++) begin
      tick();
      exp_sel = 2'((i / DWELL) % NSRC);
      exp_dig = 32'hA0 + ((i - 1) / DWELL) % NSRC;
      n_checks++; if (sel !== exp_sel) begin n_fail++; $display("FAIL auto_sel t=%0d got=%0d exp=%0d", i, sel, exp_sel); end
      n_checks++; if (digit !== exp_dig) begin n_fail++; $display("FAIL auto_digit t=%0d got=%h exp=%h", i, digit, exp_dig); end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_debounce();
    btn_next = 1'b1;
    repeat (3) tick();
    btn_next = 1'b0;
    repeat (12) tick();
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL glitch_sel got=%0d exp=0", sel); end
    btn_next = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) btn_next = 1'b0;
      if (i == 5) begin
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL press_early_sel got=%0d exp=0", sel); end
      end
      if (i == 6) begin
        n_checks++; if (sel !== 2'd1) begin n_fail++; $display("FAIL press_step_sel got=%0d exp=1", sel); end
      end
    end
    n_checks++; if (sel !== 2'd1) begin n_fail++; $display("FAIL press_once_sel got=%0d exp=1", sel); end
    n_checks++; if (digit !== 32'hA1) begin n_fail++; $display("FAIL press_digit got=%h exp=%h", digit, 32'hA1); end
  endtask

`ifdef DISP_ARB_PRIO_EN
  task automatic test_preempt();
    auto_en = 1'b1;
    repeat (DWELL) tick();
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL pre_sel got=%0d exp=2", sel); end
    pri_req = 1'b1; pri_data = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (pri_gnt !== 1'b1) begin n_fail++; $display("FAIL grant got=%b exp=1", pri_gnt); end
    n_checks++; if (digit !== 32'hA2) begin n_fail++; $display("FAIL grant_digit got=%h exp=%h", digit, 32'hA2); end
    tick();
    n_checks++; if (digit !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_digit got=%h exp=deadbeef", digit); end
    pri_data = 32'hCAFE_0001;
    tick();
    n_checks++; if (digit !== 32'hCAFE_0001) begin n_fail++; $display("FAIL prio_live got=%h exp=cafe0001", digit); end
    pri_data = 32'hDEAD_BEEF;
    tick();
    pri_req = 1'b0;
    tick();
    n_checks++; if (pri_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_gnt got=%b exp=0", pri_gnt); end
    pri_data = 32'h1111_1111;
    for (int i = 0; i < HOLD; i++) begin
      n_checks++; if (digit !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL linger_digit c=%0d got=%h exp=deadbeef", i, digit); end
      n_checks++; if (pri_active !== 1'b1) begin n_fail++; $display("FAIL linger_active c=%0d got=%b exp=1", i, pri_active); end
      tick();
    end
    n_checks++; if (pri_active !== 1'b0) begin n_fail++; $display("FAIL linger_end got=%b exp=0", pri_active); end
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL linger_sel got=%0d exp=2", sel); end
    tick();
    n_checks++; if (digit !== 32'hA2) begin n_fail++; $display("FAIL return_digit got=%h exp=%h", digit, 32'hA2); end
    repeat (DWELL - 2) tick();
    n_checks++; if (sel !== 2'd2) begin n_fail++; $display("FAIL dwell_restart_hold got=%0d exp=2", sel); end
    tick();
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL dwell_restart_adv got=%0d exp=3", sel); end
    auto_en = 1'b0;
    pri_data = 32'hDEAD_BEEF;
  endtask

  task automatic test_relinger();
    pri_req = 1'b1;
    tick(); tick();
    pri_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pri_active !== 1'b1 || digit !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL relinger_hold c=%0d active=%b digit=%h exp=1/deadbeef", i, pri_active, digit);
      end
    end
    pri_req = 1'b1;
    tick();
    n_checks++; if (pri_gnt !== 1'b1) begin n_fail++; $display("FAIL relinger_gnt got=%b exp=1", pri_gnt); end
    n_checks++; if (digit !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL relinger_digit got=%h exp=deadbeef", digit); end
    btn_next = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    repeat (10) tick();
    n_checks++; if (pri_gnt !== 1'b1) begin n_fail++; $display("FAIL prio_stays got=%b exp=1", pri_gnt); end
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL prio_step_discard got=%0d exp=3", sel); end
    pri_req = 1'b0;
    repeat (HOLD + 2) tick();
    n_checks++; if (pri_active !== 1'b0 || digit !== 32'hA3) begin
      n_fail++; $display("FAIL relinger_return active=%b digit=%h exp=0/a3", pri_active, digit);
    end
  endtask
`else
  task automatic test_prio_ignored();
    pri_req = 1'b1; pri_data = 32'hDEAD_BEEF; auto_en = 1'b1;
    repeat (2 * DWELL) tick();
    n_checks++; if (pri_gnt !== 1'b0 || pri_active !== 1'b0) begin
      n_fail++; $display("FAIL prio_off gnt=%b active=%b exp=0/0", pri_gnt, pri_active);
    end
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL prio_off_sel got=%0d exp=3", sel); end
    tick();
    n_checks++; if (digit !== 32'hA3) begin n_fail++; $display("FAIL prio_off_digit got=%h exp=%h", digit, 32'hA3); end
    pri_req = 1'b0; auto_en = 1'b0;
    tick();
  endtask
`endif

  task automatic test_collision();
    auto_en = 1'b1;
    tick();
    btn_next = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 9) btn_next = 1'b0;
      if (i == 5) begin
        n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL coll_pre got=%0d exp=3", sel); end
      end
      if (i == 6) begin
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL coll_single got=%0d exp=0", sel); end
      end
      if (i == 13) begin
        n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL coll_dwell_hold got=%0d exp=0", sel); end
      end
      if (i == 14) begin
        n_checks++; if (sel !== 2'd1) begin n_fail++; $display("FAIL coll_dwell_adv got=%0d exp=1", sel); end
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_async_reset();
`ifdef DISP_ARB_PRIO_EN
    pri_req = 1'b1;
    tick(); tick();
    n_checks++; if (pri_gnt !== 1'b1) begin n_fail++; $display("FAIL ar_pre_gnt got=%b exp=1", pri_gnt); end
`endif
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (pri_gnt !== 1'b0) begin n_fail++; $display("FAIL ar_gnt got=%b exp=0", pri_gnt); end
    n_checks++; if (digit !== 32'h0) begin n_fail++; $display("FAIL ar_digit got=%h exp=0", digit); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL ar_sel got=%0d exp=0", sel); end
    n_checks++; if (pri_active !== 1'b0) begin n_fail++; $display("FAIL ar_active got=%b exp=0", pri_active); end
    @(negedge clk);
    pri_req = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++; if (digit !== 32'hA0 || sel !== 2'd0 || pri_active !== 1'b0) begin
      n_fail++; $display("FAIL ar_release digit=%h sel=%0d active=%b exp=a0/0/0", digit, sel, pri_active);
    end
  endtask

  initial begin
    test_reset();
    test_auto_rotate();
    test_debounce();
`ifdef DISP_ARB_PRIO_EN
    test_preempt();
    test_relinger();
`else
    test_prio_ignored();
`endif
    test_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
